// File: rtl/piso_serializer.sv
// Parallel-in, serial-out transmitter: takes a WIDTH-bit word through a valid/ready
// handshake and shifts it out one bit per clock. Define PISO_PARITY_EN to append an even-parity bit.
module piso_serializer #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy,
  output logic             done
);

  localparam int                CNT_W    = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1
`ifdef PISO_PARITY_EN
    ,
    S_PAR   = 2'd2
`endif
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_q;
  logic [CNT_W-1:0] r_cnt;

  state_t           w_state_nxt;
  logic [WIDTH-1:0] w_q_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [WIDTH-1:0] w_q_shifted;
  logic             w_out_bit;
  logic             w_last_bit;
  logic             w_accept;
  logic             w_sout;
  logic             w_sout_valid;
  logic             w_load_ready;
  logic             w_done;

`ifdef PISO_PARITY_EN
  logic r_par;
  logic w_par_nxt;
`endif

  // Bits move toward the output end and the vacated end fills with zero, so the
  // register is already clear when a frame ends without a follow-on word.
  assign w_q_shifted = MSB_FIRST ? {r_q[WIDTH-2:0], 1'b0} : {1'b0, r_q[WIDTH-1:1]};
  assign w_out_bit   = MSB_FIRST ? r_q[WIDTH-1] : r_q[0];
  assign w_last_bit  = (r_state == S_SHIFT) && (r_cnt == LAST_CNT);

  always_comb begin
    // NOTE: every variable gets a default before the case so no path can infer a latch.
    w_state_nxt  = r_state;
    w_q_nxt      = r_q;
    w_cnt_nxt    = r_cnt;
    w_sout       = 1'b0;
    w_sout_valid = 1'b0;
    w_load_ready = 1'b0;
    w_done       = 1'b0;
    w_accept     = 1'b0;
`ifdef PISO_PARITY_EN
    w_par_nxt    = r_par;
`endif

    case (r_state)
      S_IDLE: begin
        w_load_ready = 1'b1;
      end

      S_SHIFT: begin
        w_sout_valid = 1'b1;
        w_sout       = w_out_bit;
        w_q_nxt      = w_q_shifted;
        w_cnt_nxt    = r_cnt + 1'b1;
`ifdef PISO_PARITY_EN
        if (w_last_bit) begin
          w_state_nxt = S_PAR;
        end
`else
        // The last data bit doubles as the accept window for a zero-gap follow-on word.
        if (w_last_bit) begin
          w_done       = 1'b1;
          w_load_ready = 1'b1;
          w_state_nxt  = S_IDLE;
        end
`endif
      end

`ifdef PISO_PARITY_EN
      S_PAR: begin
        w_sout_valid = 1'b1;
        w_sout       = r_par;
        w_done       = 1'b1;
        w_load_ready = 1'b1;
        w_state_nxt  = S_IDLE;
      end
`endif

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // An accepted word overrides the default progression from any ready state.
    w_accept = load_valid && w_load_ready;
    if (w_accept) begin
      w_state_nxt = S_SHIFT;
      w_q_nxt     = din;
      w_cnt_nxt   = '0;
`ifdef PISO_PARITY_EN
      w_par_nxt   = ^din;
`endif
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_q     <= '0;
      r_cnt   <= '0;
`ifdef PISO_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_q     <= w_q_nxt;
      r_cnt   <= w_cnt_nxt;
`ifdef PISO_PARITY_EN
      r_par   <= w_par_nxt;
`endif
    end
  end

  assign load_ready = w_load_ready;
  assign q          = r_q;
  assign sout       = w_sout;
  assign sout_valid = w_sout_valid;
  assign busy       = (r_state != S_IDLE);
  assign done       = w_done;

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: an MSB-first and an LSB-first instance share stimulus and are
// compared every cycle against a queue of bits still owed on the line.
module tb_piso_serializer;

  localparam int W = 4;
`ifdef PISO_PARITY_EN
  localparam int FL = W + 1;
  localparam logic [31:0] EXP_SINGLE_M = 32'b10111;
  localparam logic [31:0] EXP_SINGLE_L = 32'b11011;
  localparam logic [31:0] EXP_B2B_M    = 32'b1011101100;
  localparam logic [31:0] EXP_B2B_L    = 32'b1101101100;
`else
  localparam int FL = W;
  localparam logic [31:0] EXP_SINGLE_M = 32'b1011;
  localparam logic [31:0] EXP_SINGLE_L = 32'b1101;
  localparam logic [31:0] EXP_B2B_M    = 32'b10110110;
  localparam logic [31:0] EXP_B2B_L    = 32'b11010110;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] din;
  logic         load_valid;

  logic         ready_m, sout_m, sv_m, busy_m, done_m;
  logic [W-1:0] qd_m;
  logic         ready_l, sout_l, sv_l, busy_l, done_l;
  logic [W-1:0] qd_l;

  int n_assert = 0;
  int n_fail   = 0;

  bit exp_m[$];
  bit exp_l[$];
  logic [31:0] hist_m = '0;
  logic [31:0] hist_l = '0;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .din(din), .load_valid(load_valid),
    .load_ready(ready_m), .q(qd_m), .sout(sout_m), .sout_valid(sv_m),
    .busy(busy_m), .done(done_m)
  );

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .din(din), .load_valid(load_valid),
    .load_ready(ready_l), .q(qd_l), .sout(sout_l), .sout_valid(sv_l),
    .busy(busy_l), .done(done_l)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // The line owes exactly the queued bits; ready/done follow from how many remain.
  task automatic check_outputs();
    int n_m = exp_m.size();
    int n_l = exp_l.size();
    check("msb.load_ready", 32'(ready_m), 32'(n_m <= 1));
    check("msb.sout_valid", 32'(sv_m),    32'(n_m != 0));
    check("msb.busy",       32'(busy_m),  32'(n_m != 0));
    check("msb.done",       32'(done_m),  32'(n_m == 1));
    check("msb.sout",       32'(sout_m),  (n_m != 0) ? 32'(exp_m[0]) : 32'd0);
    if (n_m == 0) check("msb.q_idle", 32'(qd_m), 32'd0);
    check("lsb.load_ready", 32'(ready_l), 32'(n_l <= 1));
    check("lsb.sout_valid", 32'(sv_l),    32'(n_l != 0));
    check("lsb.busy",       32'(busy_l),  32'(n_l != 0));
    check("lsb.done",       32'(done_l),  32'(n_l == 1));
    check("lsb.sout",       32'(sout_l),  (n_l != 0) ? 32'(exp_l[0]) : 32'd0);
    if (n_l == 0) check("lsb.q_idle", 32'(qd_l), 32'd0);
    if (sv_m === 1'b1) hist_m = {hist_m[30:0], sout_m};
    if (sv_l === 1'b1) hist_l = {hist_l[30:0], sout_l};
  endtask

  task automatic model_edge(input logic rst_v, input logic lv, input logic [W-1:0] d);
    bit acc;
    if (!rst_v) begin
      exp_m.delete();
      exp_l.delete();
    end else begin
      acc = lv && (exp_m.size() <= 1);
      if (exp_m.size() != 0) void'(exp_m.pop_front());
      if (exp_l.size() != 0) void'(exp_l.pop_front());
      if (acc) begin
        for (int i = 0; i < W; i++) begin
          exp_m.push_back(d[W-1-i]);
          exp_l.push_back(d[i]);
        end
        if (FL > W) begin
          exp_m.push_back(^d);
          exp_l.push_back(^d);
        end
      end
    end
  endtask

  // Check the current cycle, then drive inputs for the next edge and advance the model.
  task automatic cycle(input logic rst_v, input logic lv, input logic [W-1:0] d);
    check_outputs();
    rst        = rst_v;
    load_valid = lv;
    din        = d;
    @(posedge clk);
    model_edge(rst_v, lv, d);
    @(negedge clk);
  endtask

  initial begin
    rst        = 1'b0;
    load_valid = 1'b0;
    din        = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset state, then a single word.
    cycle(1'b1, 1'b0, 4'b0000);
    cycle(1'b1, 1'b1, 4'b1011);
    repeat (FL) cycle(1'b1, 1'b0, 4'b0000);
    check("plan.single_msb", hist_m & ((32'd1 << FL) - 1), EXP_SINGLE_M);
    check("plan.single_lsb", hist_l & ((32'd1 << FL) - 1), EXP_SINGLE_L);
    cycle(1'b1, 1'b0, 4'b0000);

    // Back-to-back: second word held until taken on the done cycle.
    cycle(1'b1, 1'b1, 4'b1011);
    repeat (FL) cycle(1'b1, 1'b1, 4'b0110);
    repeat (FL) cycle(1'b1, 1'b0, 4'b0000);
    check("plan.b2b_msb", hist_m & ((32'd1 << (2*FL)) - 1), EXP_B2B_M);
    check("plan.b2b_lsb", hist_l & ((32'd1 << (2*FL)) - 1), EXP_B2B_L);
    cycle(1'b1, 1'b0, 4'b0000);

    // Load request arriving mid-frame waits for the done cycle.
    cycle(1'b1, 1'b1, 4'b1000);
    cycle(1'b1, 1'b0, 4'b0000);
    repeat (FL) cycle(1'b1, 1'b1, 4'b1111);
    repeat (FL + 1) cycle(1'b1, 1'b0, 4'b0000);

    // Mid-frame reset aborts the frame.
    cycle(1'b1, 1'b1, 4'b1011);
    repeat (2) cycle(1'b1, 1'b0, 4'b0000);
    cycle(1'b0, 1'b0, 4'b0000);
    repeat (FL) cycle(1'b1, 1'b0, 4'b0000);

    // Random traffic including occasional resets and din churn.
    for (int k = 0; k < 600; k++) begin
      cycle(($urandom_range(0, 39) != 0), ($urandom_range(0, 2) != 0), W'($urandom));
    end
    repeat (FL + 1) cycle(1'b1, 1'b0, 4'b0000);
    check_outputs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
